operand_pair_loader: RTL and testbench

//  Upstream stage of the two-operand adder datapath (result = A + B).

---
 rtl/operand_pkg.sv | 14 +
 rtl/operand_pair_fifo.sv | 57 +++++
 rtl/operand_pair_loader.sv | 74 +++++++
 tb/tb_operand_pair_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared types and constants for the operand pair loader.
// Covers the state encoding and the depth of the pair queue.
package operand_pkg;

    localparam logic ST_WAIT_A  = 1'b0;
    localparam logic ST_WAIT_B  = 1'b1;
    localparam int   PAIR_DEPTH = 2;

    typedef enum logic {
        WAIT_A = ST_WAIT_A,
        WAIT_B = ST_WAIT_B
    } state_e;

endpackage

// File: rtl/operand_pair_fifo.sv
// Small FIFO of {a,b} operand pairs.
// Push and pop in the same cycle are both honoured, even when the FIFO is full.
module operand_pair_fifo #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [2*WIDTH-1:0] rdata,
    output logic               empty,
    output logic               full
);
    import operand_pkg::*;

    localparam int AW = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
    localparam int CW = $clog2(PAIR_DEPTH + 1);

    logic [2*WIDTH-1:0] mem [PAIR_DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(PAIR_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(PAIR_DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < PAIR_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_pair_loader.sv
// Collects serial A/B operand beats into pairs and queues them for the adder.
// Also counts every pair handed to the adder stage.
module operand_pair_loader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             pending_a
);
    import operand_pkg::*;

    state_e             state;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] rdata;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               fire;

    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    // A B beat into a full queue is only taken when a pop frees a slot now
    assign in_ready  = !abort & !((state == WAIT_B) & full & !pop);
    assign fire      = in_valid & in_ready;
    assign push      = fire & (state == WAIT_B);
    assign out_a     = rdata[2*WIDTH-1:WIDTH];
    assign out_b     = rdata[WIDTH-1:0];
    assign pending_a = (state == WAIT_B);

    operand_pair_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .wdata({a_reg, in_data}),
        .rdata(rdata),
        .empty(empty),
        .full (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_A;
            a_reg    <= '0;
            pair_cnt <= '0;
        end else begin
            if (pop) pair_cnt <= pair_cnt + 1'b1;
            if (abort) begin
                state <= WAIT_A;
            end else if (fire) begin
                if (state == WAIT_A) begin
                    a_reg <= in_data;
                    state <= WAIT_B;
                end else begin
                    state <= WAIT_A;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_pair_loader.sv
// Self-checking bench for operand_pair_loader.
// A scoreboard of expected pairs is compared against every pop.
module tb_operand_pair_loader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [CNT_W-1:0] pair_cnt;
    logic             pending_a;

    int checks = 0;
    int errors = 0;

    logic [2*WIDTH-1:0] sb[$];
    logic [WIDTH-1:0]   a_hold = '0;
    logic               have_a = 1'b0;
    logic [CNT_W-1:0]   model_cnt = '0;

    operand_pair_loader #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .pair_cnt (pair_cnt),
        .pending_a(pending_a)
    );

    always #5 clk = ~clk;

    // Pop side: every handshake is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [2*WIDTH-1:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %h/%h, scoreboard empty", out_a, out_b);
            end else begin
                exp = sb.pop_front();
                if ({out_a, out_b} !== exp) begin
                    errors++;
                    $display("FAIL pair_data: got %h/%h, expected %h/%h",
                             out_a, out_b, exp[15:8], exp[7:0]);
                end
            end
            checks++;
            if (pair_cnt !== model_cnt) begin
                errors++;
                $display("FAIL pair_cnt_at_pop: got %0d, expected %0d", pair_cnt, model_cnt);
            end
            model_cnt = model_cnt + 1'b1;
        end
    end

    task automatic model_beat(input logic [WIDTH-1:0] d);
        if (have_a) begin
            sb.push_back({a_hold, d});
            have_a = 1'b0;
        end else begin
            a_hold = d;
            have_a = 1'b1;
        end
    endtask

    // Drives one beat and waits (bounded) for it to be accepted
    task automatic drive_beat(input logic [WIDTH-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%b for beat %h, expected 1", in_ready, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(d);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: out_valid=%b left=%0d, expected 0/0", out_valid, sb.size());
        end
    endtask

    task automatic reset_dut();
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        sb.delete();
        have_a    = 1'b0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({out_valid, pending_a, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: valid/pend/rdy=%b, expected 001",
                     {out_valid, pending_a, in_ready});
        end
        checks++;
        if ({out_a, out_b} !== 16'h0000 || pair_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h cnt=%0d, expected 0 0 0", out_a, out_b, pair_cnt);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_beat(8'h03);
        checks++;
        if (pending_a !== 1'b1) begin
            errors++;
            $display("FAIL pending_after_a: got %b, expected 1", pending_a);
        end
        in_valid = 1'b1;
        in_data  = 8'h05;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_cycle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(8'h05);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 8'h03 || out_b !== 8'h05) begin
            errors++;
            $display("FAIL latency: valid=%b a=%h b=%h, expected 1 03 05", out_valid, out_a, out_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pair_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_after_pop: got %0d, expected 1", pair_cnt);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_beat(8'h11);
        drive_beat(8'h22);
        drive_beat(8'h33);
        drive_beat(8'h44);
        drive_beat(8'h55);
        in_valid = 1'b1;
        in_data  = 8'h66;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sixth_beat_stall: in_ready=%b, expected 0", in_ready);
        end
        checks++;
        if (out_a !== 8'h11 || out_b !== 8'h22) begin
            errors++;
            $display("FAIL head_stable: a=%h b=%h, expected 11 22", out_a, out_b);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b_with_pop: in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(8'h66);
        wait_drain();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        drive_beat(8'hAA);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks: in_ready=%b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        have_a   = 1'b0;
        checks++;
        if (pending_a !== 1'b0) begin
            errors++;
            $display("FAIL pending_after_abort: got %b, expected 0", pending_a);
        end
        drive_beat(8'h01);
        drive_beat(8'h02);
        wait_drain();
    endtask

    task automatic test_full_simul();
        out_ready = 1'b0;
        drive_beat(8'hA1);
        drive_beat(8'hB1);
        drive_beat(8'hA2);
        drive_beat(8'hB2);
        drive_beat(8'hA3);
        in_valid  = 1'b1;
        in_data   = 8'hB3;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_beat(8'hB3);
        drive_beat(8'hA4);
        in_valid = 1'b1;
        in_data  = 8'hB4;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_a !== 8'hA2 || out_b !== 8'hB2) begin
            errors++;
            $display("FAIL still_full: in_ready=%b head=%h/%h, expected 0 A2/B2",
                     in_ready, out_a, out_b);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(8'hB4);
        wait_drain();
    endtask

    task automatic test_wrap();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_beat(8'(i));
            drive_beat(8'(8'hF0 - i));
        end
        wait_drain();
        checks++;
        if (pair_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d, expected 1", pair_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_beat(8'hC1);
        drive_beat(8'hC2);
        drive_beat(8'hC3);
        checks++;
        if (out_valid !== 1'b1 || pending_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b pend=%b, expected 1 1", out_valid, pending_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, pending_a} !== 2'b00 || out_a !== 8'h00 || pair_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b pend=%b a=%h cnt=%0d, expected 0 0 00 0",
                     out_valid, pending_a, out_a, pair_cnt);
        end
        sb.delete();
        have_a    = 1'b0;
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_beat(8'hD1);
        checks++;
        if (pending_a !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_is_a: pending_a=%b, expected 1", pending_a);
        end
        drive_beat(8'hD2);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_full_simul();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
